// File: rtl/sdram_port_arbiter_if.sv
// Handshake bundle between the port FIFO level logic / SDRAM command FSM
// and the SDRAM port arbiter. The arbiter connects through the slave modport;
// the request/command side connects through the master modport.
interface sdram_port_arbiter_if #(
   parameter int NPORT = 4
);
   localparam int IDW = (NPORT > 1) ? $clog2(NPORT) : 1;

   logic [NPORT-1:0] iREQ;
   logic [NPORT-1:0] iURGENT;
   logic             iREF_REQ;
   logic             iCMD_READY;
   logic             iBURST_DONE;
   logic [NPORT-1:0] oGRANT;
   logic             oGRANT_VALID;
   logic [IDW-1:0]   oGRANT_ID;
   logic             oREF_GO;
   logic             oBUSY;
   logic             oTIMEOUT_ERR;

   modport slave (
      input  iREQ, iURGENT, iREF_REQ, iCMD_READY, iBURST_DONE,
      output oGRANT, oGRANT_VALID, oGRANT_ID, oREF_GO, oBUSY, oTIMEOUT_ERR
   );

   modport master (
      output iREQ, iURGENT, iREF_REQ, iCMD_READY, iBURST_DONE,
      input  oGRANT, oGRANT_VALID, oGRANT_ID, oREF_GO, oBUSY, oTIMEOUT_ERR
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// SDRAM port arbiter: shares one SDRAM command engine between NPORT FIFO
// ports and the refresh timer. Priority is refresh > urgent reads > plain
// round-robin; one burst grant at a time, re-arbitration after completion.
// Optional feature: define SDRAM_ARB_AGING_EN to give every port a wait
// counter that promotes a starved requester to the urgent tier.
module sdram_port_arbiter #(
   parameter int               NPORT       = 4,
   parameter logic [NPORT-1:0] RD_MASK     = 4'b1100,
   parameter int               TIMEOUT_CYC = 1024,
   parameter int               MAX_WAIT    = 8
) (
   input  logic iCLK,
   input  logic iRST_N,
   sdram_port_arbiter_if.slave bus
);
   localparam int IDW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int CW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_REF} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NPORT-1:0] grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic             ref_go_q, ref_go_d;
   logic             busy_q, busy_d;
   logic             timeout_err_q, timeout_err_d;

   logic [NPORT-1:0] aged;
   logic [NPORT-1:0] urg_mask;
   logic [IDW:0]     pick_urg, pick_all;
   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic             port_win;
   logic [IDW-1:0]   ptr_next;
   logic             timed_out;

   // First set bit of m at or after position p, circularly; MSB = found.
   function automatic logic [IDW:0] rr_pick(input logic [NPORT-1:0] m,
                                            input logic [IDW-1:0] p);
      logic           found;
      logic [IDW-1:0] idx;
      int             j;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NPORT; k++) begin
         j = (int'(p) + k) % NPORT;
         if (!found && m[j]) begin
            found = 1'b1;
            idx   = IDW'(j);
         end
      end
      return {found, idx};
   endfunction

   // Urgent tier: read ports flagged urgent, plus ports aged past the wait limit.
   assign urg_mask  = (bus.iURGENT & RD_MASK & bus.iREQ) | (aged & bus.iREQ);
   assign pick_urg  = rr_pick(urg_mask, ptr_q);
   assign pick_all  = rr_pick(bus.iREQ, ptr_q);
   assign win_found = pick_urg[IDW] | pick_all[IDW];
   assign win_idx   = pick_urg[IDW] ? pick_urg[IDW-1:0] : pick_all[IDW-1:0];
   assign port_win  = (state_q == S_IDLE) && bus.iCMD_READY && !bus.iREF_REQ && win_found;
   assign ptr_next  = IDW'((int'(grant_id_q) + 1) % NPORT);
   assign timed_out = (cnt_q == CW'(TIMEOUT_CYC - 1));

`ifdef SDRAM_ARB_AGING_EN
   for (genvar gi = 0; gi < NPORT; gi++) begin : g_age
      logic [3:0] wait_cnt_q, wait_cnt_d;

      // Count lost arbitrations while requesting; clear on grant or request drop.
      always_comb begin
         wait_cnt_d = wait_cnt_q;
         if (!bus.iREQ[gi]) begin
            wait_cnt_d = '0;
         end else if (port_win) begin
            if (win_idx == IDW'(gi)) begin
               wait_cnt_d = '0;
            end else if (wait_cnt_q < 4'(MAX_WAIT)) begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
      end

      // Wait counter register.
      always_ff @(posedge iCLK or negedge iRST_N) begin
         if (!iRST_N) wait_cnt_q <= '0;
         else         wait_cnt_q <= wait_cnt_d;
      end

      assign aged[gi] = (wait_cnt_q >= 4'(MAX_WAIT));
   end
`else
   assign aged = '0;
`endif

   // Next-state and registered-output logic of the arbitration FSM.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      cnt_d         = cnt_q;
      grant_d       = grant_q;
      grant_valid_d = 1'b0;
      ref_go_d      = 1'b0;
      busy_d        = busy_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (bus.iCMD_READY) begin
               if (bus.iREF_REQ) begin
                  state_d  = S_REF;
                  ref_go_d = 1'b1;
                  busy_d   = 1'b1;
                  cnt_d    = '0;
               end else if (win_found) begin
                  state_d          = S_GRANT;
                  grant_valid_d    = 1'b1;
                  grant_d          = '0;
                  grant_d[win_idx] = 1'b1;
                  grant_id_d       = win_idx;
                  busy_d           = 1'b1;
               end
            end
         end
         S_GRANT: begin
            state_d = S_BURST;
            cnt_d   = '0;
         end
         S_BURST: begin
            if (bus.iBURST_DONE || timed_out) begin
               state_d    = S_IDLE;
               grant_d    = '0;
               grant_id_d = '0;
               busy_d     = 1'b0;
               ptr_d      = ptr_next;
               if (!bus.iBURST_DONE) timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_REF: begin
            if (bus.iBURST_DONE || timed_out) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               if (!bus.iBURST_DONE) timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset drops any grant immediately.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         grant_id_q    <= '0;
         cnt_q         <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         ref_go_q      <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         cnt_q         <= cnt_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         ref_go_q      <= ref_go_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.oGRANT       = grant_q;
   assign bus.oGRANT_VALID = grant_valid_q;
   assign bus.oGRANT_ID    = grant_id_q;
   assign bus.oREF_GO      = ref_go_q;
   assign bus.oBUSY        = busy_q;
   assign bus.oTIMEOUT_ERR = timeout_err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed and randomized arbitration rounds.
// The stimulus side predicts each grant/refresh from a queue-free reference
// model (pointer + per-port wait counts) and pushes it to a scoreboard; a
// negedge monitor pops and compares whenever the arbiter issues something.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
   localparam int         NPORT       = 4;
   localparam logic [3:0] RD_MASK     = 4'b1100;
   localparam int         TIMEOUT_CYC = 1024;
   localparam int         MAX_WAIT    = 8;

   logic iCLK   = 1'b0;
   logic iRST_N = 1'b0;

   sdram_port_arbiter_if #(.NPORT(NPORT)) bus ();

   sdram_port_arbiter #(
      .NPORT(NPORT), .RD_MASK(RD_MASK), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .bus(bus)
   );

   always #5 iCLK = ~iCLK;

   // kind: 1 = refresh, 2 = port grant
   typedef struct { int kind; int id; } exp_t;
   exp_t exp_q[$];

   int checks = 0, errors = 0;
   int cyc = 0, last_gcyc = 0, prev_gcyc = 0, last_gid = -1;
   int m_ptr = 0;
   int m_wait[4];
   bit ref_level = 1'b0;

   always @(posedge iCLK) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int rr_first(input logic [3:0] m);
      for (int k = 0; k < 4; k++) begin
         if (m[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic exp_t model_arb(input logic [3:0] req, input logic [3:0] urg,
                                      input bit ref_in, input bit rdy);
      exp_t e;
      logic [3:0] u;
      int w;
      e.kind = 0;
      e.id   = 0;
      if (!rdy) return e;
      if (ref_in) begin
         e.kind = 1;
         return e;
      end
      u = req & urg & RD_MASK;
`ifdef SDRAM_ARB_AGING_EN
      for (int p = 0; p < 4; p++) if (req[p] && m_wait[p] >= MAX_WAIT) u[p] = 1'b1;
`endif
      w = (u != 4'b0) ? rr_first(u) : rr_first(req);
      if (w < 0) return e;
      e.kind = 2;
      e.id   = w;
`ifdef SDRAM_ARB_AGING_EN
      for (int p = 0; p < 4; p++) begin
         if (p == w) m_wait[p] = 0;
         else if (req[p] && m_wait[p] < MAX_WAIT) m_wait[p]++;
      end
`endif
      return e;
   endfunction

   task automatic set_req(input logic [3:0] r);
      bus.iREQ = r;
      for (int p = 0; p < 4; p++) if (!r[p]) m_wait[p] = 0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge iCLK) begin : monitor
      exp_t e;
      logic [3:0] oh;
      if (iRST_N && (bus.oGRANT_VALID || bus.oREF_GO)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue cyc=%0d: got valid=%0b ref_go=%0b grant=%b, required nothing",
                     cyc, bus.oGRANT_VALID, bus.oREF_GO, bus.oGRANT);
         end else begin
            e = exp_q.pop_front();
            if (e.kind == 1) begin
               if (!(bus.oREF_GO && !bus.oGRANT_VALID && bus.oGRANT == 4'b0 && bus.oBUSY)) begin
                  errors++;
                  $display("FAIL refresh_issue cyc=%0d: got ref_go=%0b valid=%0b grant=%b busy=%0b, required ref_go=1 valid=0 grant=0000 busy=1",
                           cyc, bus.oREF_GO, bus.oGRANT_VALID, bus.oGRANT, bus.oBUSY);
               end else begin
                  $display("txn cyc=%0d refresh", cyc);
               end
            end else begin
               oh = 4'b0001 << e.id;
               if (!(bus.oGRANT_VALID && !bus.oREF_GO && bus.oGRANT == oh &&
                     bus.oGRANT_ID == 2'(e.id) && bus.oBUSY)) begin
                  errors++;
                  $display("FAIL port_grant cyc=%0d: got valid=%0b ref_go=%0b grant=%b id=%0d busy=%0b, required valid=1 ref_go=0 grant=%b id=%0d busy=1",
                           cyc, bus.oGRANT_VALID, bus.oREF_GO, bus.oGRANT, bus.oGRANT_ID, bus.oBUSY, oh, e.id);
               end else begin
                  $display("txn cyc=%0d grant port %0d", cyc, e.id);
               end
            end
         end
         if (bus.oGRANT_VALID) begin
            prev_gcyc = last_gcyc;
            last_gcyc = cyc;
            last_gid  = int'(bus.oGRANT_ID);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset();
      iRST_N          = 1'b0;
      bus.iREQ        = '0;
      bus.iURGENT     = '0;
      bus.iREF_REQ    = 1'b0;
      bus.iCMD_READY  = 1'b0;
      bus.iBURST_DONE = 1'b0;
      repeat (2) @(negedge iCLK);
      check("reset_outputs", {bus.oGRANT, bus.oGRANT_VALID, bus.oGRANT_ID,
                              bus.oREF_GO, bus.oBUSY, bus.oTIMEOUT_ERR}, 0);
      m_ptr     = 0;
      for (int p = 0; p < 4; p++) m_wait[p] = 0;
      ref_level = 1'b0;
      exp_q.delete();
      iRST_N    = 1'b1;
   endtask

   // One arbitration opportunity, starting and ending at a negedge in IDLE.
   task automatic do_round(input logic [3:0] req, input logic [3:0] urg, input bit ref_in,
                           input bit rdy, input int blen, input bit drop,
                           input bit spurious, input bit ref_mid);
      exp_t e;
      if (ref_in) ref_level = 1'b1;
      set_req(req);
      bus.iURGENT    = urg;
      bus.iREF_REQ   = ref_level;
      bus.iCMD_READY = rdy;
      e = model_arb(req, urg, ref_level, rdy);
      if (e.kind == 0) begin
         @(negedge iCLK);
         bus.iCMD_READY = 1'b0;
         return;
      end
      exp_q.push_back(e);
      @(negedge iCLK);
      bus.iCMD_READY = 1'b0;
      if (e.kind == 2) begin
         if (spurious) bus.iBURST_DONE = 1'b1;
         if (drop) set_req(req & 4'($urandom));
         if (ref_mid) begin
            ref_level    = 1'b1;
            bus.iREF_REQ = 1'b1;
         end
         @(negedge iCLK);
         bus.iBURST_DONE = 1'b0;
      end
      repeat (blen - 1) @(negedge iCLK);
      if (e.kind == 2) check("grant_held", int'(bus.oGRANT), 1 << e.id);
      bus.iBURST_DONE = 1'b1;
      @(negedge iCLK);
      bus.iBURST_DONE = 1'b0;
      if (e.kind == 1) begin
         ref_level    = 1'b0;
         bus.iREF_REQ = 1'b0;
      end else begin
         m_ptr = (e.id + 1) % 4;
      end
      check("released_after_done", {bus.oGRANT, bus.oBUSY}, 0);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      exp_t e;
      int n;

      // Single request after reset.
      do_reset();
      do_round(4'b0001, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("first_grant_id", last_gid, 0);
      // Command engine not ready: no grant may appear.
      do_round(4'b0001, 4'b0000, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);

      // Round-robin over all four ports, immediate completion.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         do_round(4'b1111, 4'b0000, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
         check("rr_order", last_gid, k % 4);
         if (k > 0) check("grant_spacing", last_gcyc - prev_gcyc, 3);
      end

      // Urgent read port first, then round-robin.
      do_reset();
      do_round(4'b0111, 4'b0100, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("urgent_first", last_gid, 2);
      do_round(4'b0111, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("after_urgent_a", last_gid, 0);
      do_round(4'b0111, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("after_urgent_b", last_gid, 1);

      // Refresh beats a pending port request.
      do_reset();
      do_round(4'b0001, 4'b0000, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
      do_round(4'b0001, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("grant_after_refresh", last_gid, 0);

      // Urgent on a write port, and urgent without request, are ignored.
      do_reset();
      do_round(4'b0011, 4'b0010, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("write_urgent_ignored", last_gid, 0);
      do_round(4'b0101, 4'b1000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("urgent_no_req_ignored", last_gid, 2);

      // Burst timeout on port 1.
      do_reset();
      set_req(4'b0110);
      bus.iURGENT    = 4'b0000;
      bus.iCMD_READY = 1'b1;
      e = model_arb(4'b0110, 4'b0000, 1'b0, 1'b1);
      exp_q.push_back(e);
      @(negedge iCLK);
      bus.iCMD_READY = 1'b0;
      n = 0;
      while (!bus.oTIMEOUT_ERR && n < TIMEOUT_CYC + 100) begin
         @(negedge iCLK);
         n++;
      end
      check("timeout_latency", n, TIMEOUT_CYC + 1);
      check("timeout_released", {bus.oGRANT, bus.oBUSY}, 0);
      m_ptr = (e.id + 1) % 4;
      do_round(4'b0110, 4'b0000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      check("grant_after_timeout", last_gid, 2);
      check("timeout_sticky", int'(bus.oTIMEOUT_ERR), 1);

      // Asynchronous reset in the middle of a burst.
      do_reset();
      set_req(4'b0001);
      bus.iCMD_READY = 1'b1;
      e = model_arb(4'b0001, 4'b0000, 1'b0, 1'b1);
      exp_q.push_back(e);
      @(negedge iCLK);
      bus.iCMD_READY = 1'b0;
      @(negedge iCLK);
      #2 iRST_N = 1'b0;
      #1 check("async_reset_drop", {bus.oGRANT, bus.oBUSY}, 0);
      do_reset();

      // Starvation of port 0 by two urgent read ports.
      n        = 0;
      last_gid = -1;
      while (n < 12 && last_gid != 0) begin
         do_round(4'b1101, 4'b1100, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
         n++;
      end
`ifdef SDRAM_ARB_AGING_EN
      check("aging_rounds_to_port0", n, MAX_WAIT + 1);
`else
      check("port0_starved", int'(last_gid == 0), 0);
`endif

      // Randomized rounds.
      do_reset();
      for (int r = 0; r < 150; r++) begin
         do_round(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) != 0), int'($urandom_range(1, 4)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0));
      end
      repeat (3) @(negedge iCLK);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
